// File: rtl/present_serial_enc.sv
// Serialised PRESENT-80 encryption engine built around one shared S-box.
// Ports: clk, rst (async high), req/ptext/key in; ack in; busy, done, ctext out.
module present_serial_enc #(
  parameter int ROUNDS = 31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [63:0] ptext,
  input  logic [79:0] key,
  input  logic        ack,
  output logic        busy,
  output logic        done,
  output logic [63:0] ctext
);

  typedef enum logic [2:0] {
    IDLE,
    ADD,
    SUB,
    PERM,
    DONE
  } state_t;

  state_t      state;
  state_t      nxt;
  logic [63:0] s;
  logic [79:0] k;
  logic [5:0]  round;
  logic [3:0]  idx;
  logic [3:0]  sbox_in;
  logic [3:0]  sbox_out;
  logic [79:0] krot;
  logic [79:0] knew;
  logic [63:0] s_add;
  logic [63:0] s_perm;
  logic        last;

  assign krot  = {k[18:0], k[79:19]};
  assign s_add = s ^ k[79:16];
  assign last  = (round == 6'(ROUNDS + 1));

  // One S-box shared between the state nibble walk and the key update
  always_comb begin
    sbox_in = 4'h0;
    unique case (state)
      SUB:     sbox_in = s[{idx, 2'b00} +: 4];
      PERM:    sbox_in = krot[79:76];
      default: sbox_in = 4'h0;
    endcase
  end

  always_comb begin
    sbox_out = 4'h0;
    unique case (sbox_in)
      4'h0: sbox_out = 4'hC;
      4'h1: sbox_out = 4'h5;
      4'h2: sbox_out = 4'h6;
      4'h3: sbox_out = 4'hB;
      4'h4: sbox_out = 4'h9;
      4'h5: sbox_out = 4'h0;
      4'h6: sbox_out = 4'hA;
      4'h7: sbox_out = 4'hD;
      4'h8: sbox_out = 4'h3;
      4'h9: sbox_out = 4'hE;
      4'hA: sbox_out = 4'hF;
      4'hB: sbox_out = 4'h8;
      4'hC: sbox_out = 4'h4;
      4'hD: sbox_out = 4'h7;
      4'hE: sbox_out = 4'h1;
      4'hF: sbox_out = 4'h2;
    endcase
  end

  for (genvar j = 0; j < 63; j++) begin : g_perm
    assign s_perm[(16 * j) % 63] = s[j];
  end
  assign s_perm[63] = s[63];

  assign knew = {sbox_out, krot[75:20],
                 krot[19:15] ^ round[4:0],
                 krot[14:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (req) nxt = ADD;
      ADD:     nxt = last ? DONE : SUB;
      SUB:     if (idx == 4'd15) nxt = PERM;
      PERM:    nxt = ADD;
      DONE:    if (ack) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s     <= '0;
      k     <= '0;
      ctext <= '0;
      round <= 6'd1;
      idx   <= 4'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req) begin
            s     <= ptext;
            k     <= key;
            round <= 6'd1;
          end
        end
        ADD: begin
          s <= s_add;
          if (last) ctext <= s_add;
          else      idx   <= 4'd0;
        end
        SUB: begin
          s[{idx, 2'b00} +: 4] <= sbox_out;
          idx <= idx + 4'd1;
        end
        PERM: begin
          s     <= s_perm;
          k     <= knew;
          round <= round + 6'd1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == ADD) || (state == SUB) || (state == PERM);
  assign done = (state == DONE);

endmodule

// File: tb/tb_present_serial_enc.sv
// Scoreboard bench for present_serial_enc (31-round and 1-round instances).
// Expected ciphertexts are pushed on start and popped when done rises.
module tb_present_serial_enc;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, ack, req1, ack1;
  logic [63:0] ptext;
  logic [79:0] key;
  logic        busy, done, busy1, done1;
  logic [63:0] ctext, ctext1;

  int checks = 0;
  int errors = 0;
  logic [63:0] sb[$];
  logic [63:0] sb1[$];

  localparam logic [63:0] V1 = 64'h5579C1387B228445;
  localparam logic [63:0] V2 = 64'hE72C46C0F5945049;
  localparam logic [63:0] V3 = 64'hA112FFC72F68417B;
  localparam logic [63:0] V4 = 64'h3333DCD3213210D2;
  localparam logic [79:0] K1 = {80{1'b1}};
  localparam logic [63:0] P1 = {64{1'b1}};

  always #5 clk = ~clk;

  present_serial_enc #(.ROUNDS(31)) dut (
    .clk(clk), .rst(rst), .req(req), .ptext(ptext), .key(key),
    .ack(ack), .busy(busy), .done(done), .ctext(ctext)
  );

  present_serial_enc #(.ROUNDS(1)) dut1 (
    .clk(clk), .rst(rst), .req(req1), .ptext(ptext), .key(key),
    .ack(ack1), .busy(busy1), .done(done1), .ctext(ctext1)
  );

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [63:0] t;
    t = 64'h21748FE3DA09B65C;
    return t[{x, 2'b00} +: 4];
  endfunction

  function automatic logic [63:0] present_ref(input logic [63:0] p,
                                              input logic [79:0] k0,
                                              input int r);
    logic [63:0] st, t;
    logic [79:0] kk;
    st = p;
    kk = k0;
    for (int rr = 1; rr <= r; rr++) begin
      st = st ^ kk[79:16];
      for (int i = 0; i < 16; i++) st[4*i +: 4] = sbox(st[4*i +: 4]);
      t = '0;
      for (int j = 0; j < 64; j++) t[(j == 63) ? 63 : (16 * j) % 63] = st[j];
      st = t;
      kk = {kk[18:0], kk[79:19]};
      kk[79:76] = sbox(kk[79:76]);
      kk[19:15] = kk[19:15] ^ 5'(rr);
    end
    return st ^ kk[79:16];
  endfunction

  // Called at a negedge; leaves at the negedge after the accepting edge.
  task automatic start0(input logic [63:0] p, input logic [79:0] k,
                        input logic [63:0] exp);
    ptext = p;
    key   = k;
    req   = 1'b1;
    sb.push_back(exp);
    @(negedge clk);
    req   = 1'b0;
    ptext = {$urandom, $urandom};
    key   = {$urandom, $urandom, 16'($urandom)};
  endtask

  task automatic wait_done0(output int cyc);
    cyc = 0;
    while (!done && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic ack0;
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; req = 0; ack = 0; req1 = 0; ack1 = 0;
    ptext = '0; key = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || ctext !== 64'h0) begin
      errors++;
      $display("FAIL reset0 busy=%b done=%b ctext=%h want 0 0 0",
               busy, done, ctext);
    end
    checks++;
    if (busy1 !== 1'b0 || done1 !== 1'b0 || ctext1 !== 64'h0) begin
      errors++;
      $display("FAIL reset1 busy=%b done=%b ctext=%h want 0 0 0",
               busy1, done1, ctext1);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_zero;
    int cyc;
    logic [63:0] e;
    start0(64'h0, 80'h0, V1);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL t1_busy got %b want 1", busy);
    end
    wait_done0(cyc);
    checks++;
    if (cyc != 559) begin
      errors++;
      $display("FAIL t1_latency got %0d want 559", cyc);
    end
    e = sb.pop_front();
    checks++;
    if (ctext !== e || busy !== 1'b0) begin
      errors++;
      $display("FAIL t1_ctext got %h busy %b want %h busy 0", ctext, busy, e);
    end
    ack0();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL t1_ackdrop done=%b want 0", done);
    end
  endtask

  task automatic test_key_ones;
    int cyc;
    logic [63:0] e;
    start0(64'h0, K1, V2);
    wait_done0(cyc);
    e = sb.pop_front();
    checks++;
    if (cyc != 559 || ctext !== e) begin
      errors++;
      $display("FAIL t2 lat=%0d ctext=%h want 559 %h", cyc, ctext, e);
    end
    ack0();
  endtask

  task automatic test_back_to_back;
    int cyc;
    logic [63:0] e;
    start0(P1, 80'h0, V3);
    wait_done0(cyc);
    e = sb.pop_front();
    checks++;
    if (cyc != 559 || ctext !== e) begin
      errors++;
      $display("FAIL t3a lat=%0d ctext=%h want 559 %h", cyc, ctext, e);
    end
    ack0();
    start0(P1, K1, V4);
    wait_done0(cyc);
    checks++;
    if (cyc != 559) begin
      errors++;
      $display("FAIL t3b_latency got %0d want 559", cyc);
    end
    e = sb.pop_front();
    for (int i = 0; i < 10; i++) begin
      req = (i == 4);
      checks++;
      if (ctext !== e || done !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL t3b_hold[%0d] ctext=%h done=%b busy=%b want %h 1 0",
                 i, ctext, done, busy, e);
      end
      @(negedge clk);
    end
    req = 1'b0;
    ack0();
  endtask

  task automatic test_req_ignored;
    int cyc;
    logic [63:0] e;
    start0(64'h0, 80'h0, V1);
    cyc = 0;
    while (!done && cyc < 2000) begin
      req = (cyc == 5 || cyc == 200);
      ptext = {$urandom, $urandom};
      ack = (cyc == 100);
      @(negedge clk);
      cyc++;
    end
    req = 1'b0;
    ack = 1'b0;
    e = sb.pop_front();
    checks++;
    if (cyc != 559 || ctext !== e) begin
      errors++;
      $display("FAIL t4 lat=%0d ctext=%h want 559 %h", cyc, ctext, e);
    end
    req = 1'b1;
    ack = 1'b1;
    @(negedge clk);
    req = 1'b0;
    ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL t4_reqack[%0d] busy=%b done=%b want 0 0",
                 i, busy, done);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_async_reset;
    int cyc;
    logic [63:0] e;
    start0(P1, K1, V4);
    repeat (118) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL t5_midrun busy=%b want 1", busy);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || ctext !== 64'h0) begin
      errors++;
      $display("FAIL t5_async busy=%b done=%b ctext=%h want 0 0 0",
               busy, done, ctext);
    end
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    start0(64'h0, 80'h0, V1);
    wait_done0(cyc);
    e = sb.pop_front();
    checks++;
    if (cyc != 559 || ctext !== e) begin
      errors++;
      $display("FAIL t5_restart lat=%0d ctext=%h want 559 %h", cyc, ctext, e);
    end
    ack0();
  endtask

  task automatic test_one_round;
    int cyc;
    logic [63:0] e;
    ptext = 64'h0;
    key   = 80'h0;
    req1  = 1'b1;
    sb1.push_back(present_ref(64'h0, 80'h0, 1));
    @(negedge clk);
    req1  = 1'b0;
    ptext = {$urandom, $urandom};
    cyc = 0;
    while (!done1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    e = sb1.pop_front();
    checks++;
    if (cyc != 19 || ctext1 !== e) begin
      errors++;
      $display("FAIL t6 lat=%0d ctext=%h want 19 %h", cyc, ctext1, e);
    end
    ptext = 64'h0123456789ABCDEF;
    key   = 80'hFEDCBA9876543210ACE1;
    ack1  = 1'b1;
    @(negedge clk);
    ack1  = 1'b0;
    req1  = 1'b1;
    sb1.push_back(present_ref(ptext, key, 1));
    @(negedge clk);
    req1  = 1'b0;
    cyc = 0;
    while (!done1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    e = sb1.pop_front();
    checks++;
    if (cyc != 19 || ctext1 !== e) begin
      errors++;
      $display("FAIL t6b lat=%0d ctext=%h want 19 %h", cyc, ctext1, e);
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_key_ones();
    test_back_to_back();
    test_req_ignored();
    test_async_reset();
    test_one_round();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
